// File: rtl/mem_spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : mem_spi_flash_reader
// Brief    : M-port read slave served from SPI NOR flash (READ 0x03, mode 0).
//            Define MEM_SPI_FLASH_READER_CACHE_EN for a one-word read buffer.
// Revision : 1.0
// ============================================================================
module mem_spi_flash_reader #(
  parameter logic [31:0] MEM_BYTES  = 32'h0000_8000,
  parameter int unsigned SCLK_DIV   = 2,
  parameter logic [23:0] FLASH_BASE = 24'h00_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEN,
  input  logic [31:0] MADDR,
  input  logic [31:0] MDIN,
  input  logic [3:0]  MWE,
  output logic [31:0] MDOUT,
  output logic        MDONE,
  output logic        MERROR,
  output logic        spi_csn,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REJECT = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef MEM_SPI_FLASH_READER_CACHE_EN
  localparam logic [2:0] S_HIT    = 3'd5;
`endif
  localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);
  localparam logic [7:0] CMD_READ = 8'h03;

  logic [2:0]  state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [5:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;
  logic        half_q, half_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] mdout_q, mdout_d;

  logic        req_bad;
  logic [23:0] req_addr;
  logic        half_end;
  logic        shift_last;
  logic [31:0] rx_word;
  logic [63:0] frame;
  logic        unused_mdin;

  assign req_bad    = (|MWE) || (MADDR >= MEM_BYTES);
  assign req_addr   = FLASH_BASE + {MADDR[23:2], 2'b00};
  assign half_end   = (div_q == DIV_LAST);
  assign shift_last = half_q && half_end && (bit_q == 6'd63);
  // Flash returns the lowest-addressed byte first; it lands in MDOUT[7:0].
  assign rx_word    = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
  assign frame      = {CMD_READ, addr_q, 32'h0000_0000};
  assign unused_mdin = ^MDIN;

`ifdef MEM_SPI_FLASH_READER_CACHE_EN
  logic [23:0] tag_q, tag_d;
  logic [31:0] cdata_q, cdata_d;
  logic        valid_q, valid_d;
  logic        cache_hit;

  assign cache_hit = valid_q && (tag_q == req_addr);

  always_comb begin
    tag_d   = tag_q;
    cdata_d = cdata_q;
    valid_d = valid_q;
    if (state_q == S_SHIFT && shift_last) begin
      tag_d   = addr_q;
      cdata_d = rx_word;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tag_q   <= 24'h00_0000;
      cdata_q <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      cdata_q <= cdata_d;
      valid_q <= valid_d;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (MEN) begin
          if (req_bad) begin
            state_d = S_REJECT;
          end
`ifdef MEM_SPI_FLASH_READER_CACHE_EN
          else if (cache_hit) begin
            state_d = S_HIT;
          end
`endif
          else begin
            state_d = S_SELECT;
          end
        end
      end
      S_REJECT: state_d = S_IDLE;
      S_SELECT: state_d = S_SHIFT;
      S_SHIFT:  if (shift_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
`ifdef MEM_SPI_FLASH_READER_CACHE_EN
      S_HIT:    state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    bit_d   = bit_q;
    div_d   = div_q;
    half_d  = half_q;
    rx_d    = rx_q;
    mdout_d = mdout_q;
    case (state_q)
      S_IDLE: begin
        bit_d  = 6'd0;
        div_d  = 8'd0;
        half_d = 1'b0;
        if (MEN && !req_bad) begin
          addr_d = req_addr;
`ifdef MEM_SPI_FLASH_READER_CACHE_EN
          if (cache_hit) mdout_d = cdata_q;
`endif
        end
      end
      S_SHIFT: begin
        if (half_end) begin
          div_d  = 8'd0;
          half_d = !half_q;
          // Low-to-high transition raises sclk: that edge samples miso.
          if (half_q) begin
            bit_d = bit_q + 6'd1;
          end else if (bit_q[5]) begin
            rx_d = {rx_q[30:0], spi_miso};
          end
        end else begin
          div_d = div_q + 8'd1;
        end
        if (shift_last) mdout_d = rx_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q  <= 24'h00_0000;
      bit_q   <= 6'd0;
      div_q   <= 8'd0;
      half_q  <= 1'b0;
      rx_q    <= 32'h0000_0000;
      mdout_q <= 32'h0000_0000;
    end else begin
      addr_q  <= addr_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      half_q  <= half_d;
      rx_q    <= rx_d;
      mdout_q <= mdout_d;
    end
  end

  always_comb begin
    spi_csn  = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    MDONE    = 1'b0;
    MERROR   = 1'b0;
    case (state_q)
      S_SELECT: begin
        spi_csn  = 1'b0;
        spi_mosi = frame[6'd63 - bit_q];
      end
      S_SHIFT: begin
        spi_csn  = 1'b0;
        spi_sclk = half_q;
        spi_mosi = frame[6'd63 - bit_q];
      end
      S_REJECT: begin
        MDONE  = 1'b1;
        MERROR = 1'b1;
      end
      S_DONE: MDONE = 1'b1;
`ifdef MEM_SPI_FLASH_READER_CACHE_EN
      S_HIT:  MDONE = 1'b1;
`endif
      default: ;
    endcase
  end

  assign MDOUT = mdout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_spi_flash_reader
// Brief    : Self-checking bench with a behavioural SPI flash and access model.
// Revision : 1.0
// ============================================================================
module tb_mem_spi_flash_reader;

  localparam logic [31:0] MEM_BYTES  = 32'h0000_8000;
  localparam int          SCLK_DIV   = 2;
  localparam logic [23:0] FLASH_BASE = 24'h00_0000;
  localparam int          FULL_LAT   = 128 * SCLK_DIV + 2;
  localparam int          LAT_BOUND  = 2000;
`ifdef MEM_SPI_FLASH_READER_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MEN = 1'b0;
  logic [31:0] MADDR = 32'h0;
  logic [31:0] MDIN = 32'h0;
  logic [3:0]  MWE = 4'h0;
  logic [31:0] MDOUT;
  logic        MDONE, MERROR, spi_csn, spi_sclk, spi_mosi;
  logic        spi_miso = 1'b0;

  mem_spi_flash_reader #(
    .MEM_BYTES (MEM_BYTES),
    .SCLK_DIV  (SCLK_DIV),
    .FLASH_BASE(FLASH_BASE)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .MEN     (MEN),
    .MADDR   (MADDR),
    .MDIN    (MDIN),
    .MWE     (MWE),
    .MDOUT   (MDOUT),
    .MDONE   (MDONE),
    .MERROR  (MERROR),
    .spi_csn (spi_csn),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [0:32767];

  // Behavioural SPI NOR flash: 32 header bits in, then 32 data bits out.
  int          fl_cnt = 0;
  logic [31:0] fl_sh = 32'h0;
  logic [31:0] last_hdr = 32'h0;
  int          frames = 0;
  int          sclk_rises = 0;
  int          csn_falls = 0;
  int          data_mosi_ones = 0;
  time         csn_rise_t = 0;
  int          last_gap = 0;
  int          fl_d;
  logic [14:0] fl_ba;

  always @(posedge spi_csn) csn_rise_t = $time;

  always @(posedge spi_sclk or negedge spi_csn) begin
    if (spi_sclk) begin
      sclk_rises++;
      if (fl_cnt < 32) begin
        fl_sh = {fl_sh[30:0], spi_mosi};
        if (fl_cnt == 31) begin
          last_hdr = fl_sh;
          frames++;
        end
      end else if (spi_mosi) begin
        data_mosi_ones++;
      end
      fl_cnt++;
    end else begin
      fl_cnt = 0;
      csn_falls++;
      last_gap = int'(($time - csn_rise_t) / 10);
    end
  end

  always @(negedge spi_sclk) begin
    if (!spi_csn && fl_cnt >= 32 && fl_cnt < 64) begin
      fl_d     = fl_cnt - 32;
      fl_ba    = fl_sh[14:0] + 15'(fl_d / 8);
      spi_miso = mem[fl_ba][7 - (fl_d % 8)];
    end
  end

  // Access-level reference model
  bit          m_valid = 1'b0;
  logic [23:0] m_tag = 24'h0;
  logic [31:0] m_cdata = 32'h0;
  logic [31:0] m_prev = 32'h0;

  task automatic model_reset();
    m_valid = 1'b0;
    m_prev  = 32'h0;
  endtask

  task automatic model_access(input logic [31:0] a, input logic [3:0] we,
                              output int lat, output bit err,
                              output logic [31:0] d, output int edges);
    logic [23:0] fa;
    logic [14:0] ix;
    fa = FLASH_BASE + {a[23:2], 2'b00};
    ix = fa[14:0];
    if (we != 4'h0 || a >= MEM_BYTES) begin
      lat = 1; err = 1'b1; d = m_prev; edges = 0;
    end else if (CACHE && m_valid && m_tag == fa) begin
      lat = 1; err = 1'b0; d = m_cdata; edges = 0;
    end else begin
      lat = FULL_LAT; err = 1'b0; edges = 64;
      d = {mem[ix + 15'd3], mem[ix + 15'd2], mem[ix + 15'd1], mem[ix]};
      m_valid = 1'b1; m_tag = fa; m_cdata = d;
    end
    m_prev = d;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (MDONE !== 1'b1 && lat < LAT_BOUND) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic run_access(input string name, input logic [31:0] a, input logic [3:0] we,
                            output int lat, output logic err);
    int elat, eedges, r0, f0, fr0, m0;
    bit eerr;
    logic [31:0] ed;
    logic [23:0] fa;
    model_access(a, we, elat, eerr, ed, eedges);
    fa = FLASH_BASE + {a[23:2], 2'b00};
    r0 = sclk_rises; f0 = csn_falls; fr0 = frames; m0 = data_mosi_ones;
    MADDR = a; MWE = we; MDIN = $urandom; MEN = 1'b1;
    @(posedge CLK); #1;
    MEN = 1'b0;
    wait_done(lat);
    err = MERROR;
    check({name, " mdone"}, 32'(MDONE), 32'd1);
    check({name, " latency"}, lat, elat);
    check({name, " merror"}, 32'(MERROR), 32'(eerr));
    check({name, " mdout"}, MDOUT, ed);
    check({name, " sclk_edges"}, sclk_rises - r0, eedges);
    check({name, " csn_falls"}, csn_falls - f0, (eedges != 0) ? 1 : 0);
    if (eedges != 0) begin
      check({name, " header"}, last_hdr, {8'h03, fa});
      check({name, " frames"}, frames - fr0, 1);
      check({name, " mosi_data_zero"}, data_mosi_ones - m0, 0);
    end
    @(posedge CLK); #1;
    check({name, " pulse_end"}, {31'b0, MDONE, MERROR}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic        exp_err;
    int          exp_lat;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];
  int          lat, elat, eedges, r;
  bit          eerr;
  logic        err;
  logic [31:0] ed, a;
  logic [3:0]  we;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    mem[16] = 8'hEF; mem[17] = 8'hBE; mem[18] = 8'hAD; mem[19] = 8'hDE;

    vecs[0] = '{32'h0000_0010, 4'h0, 1'b0, FULL_LAT, 1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0004, 4'hF, 1'b1, 1,        1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{32'h0000_8000, 4'h0, 1'b1, 1,        1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_7FFC, 4'h0, 1'b0, FULL_LAT, 1'b0, 32'h0};
    vecs[4] = '{32'h0000_0013, 4'h0, 1'b0, FULL_LAT, 1'b1, 32'hDEAD_BEEF};
    vecs[5] = '{32'h0000_0020, 4'h1, 1'b1, 1,        1'b1, 32'hDEAD_BEEF};
    vecs[6] = '{32'hFFFF_FFFF, 4'h0, 1'b1, 1,        1'b1, 32'hDEAD_BEEF};
    vecs[7] = '{32'h0100_0010, 4'h0, 1'b1, 1,        1'b1, 32'hDEAD_BEEF};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("reset mdout", MDOUT, 32'h0);
    check("reset mdone_merror", {30'b0, MDONE, MERROR}, 32'h0);
    check("reset spi", {29'b0, spi_csn, spi_sclk, spi_mosi}, 32'h4);
    RESET = 1'b0;
    model_reset();
    @(posedge CLK); #1;

    for (int i = 0; i < 8; i++) begin
      run_access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, lat, err);
      check($sformatf("vec%0d tbl_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d tbl_lat", i), lat, vecs[i].exp_lat);
      if (vecs[i].chk_data) check($sformatf("vec%0d tbl_data", i), MDOUT, vecs[i].exp_data);
    end

    for (int i = 0; i < 12; i++) begin
      r = int'($urandom_range(0, 9));
      we = 4'h0;
      if (r < 2) begin
        a  = $urandom_range(0, 32'h7FFF);
        we = 4'($urandom_range(1, 15));
      end else if (r == 2) begin
        a = $urandom | 32'h0000_8000;
      end else if (r == 3) begin
        a = 32'h0000_0010;
      end else begin
        a = $urandom_range(0, 32'h7FFF);
      end
      run_access($sformatf("rand%0d", i), a, we, lat, err);
    end

    // Asynchronous reset in the middle of SHIFT (around bit 20)
    MADDR = 32'h10; MWE = 4'h0; MEN = 1'b1;
    @(posedge CLK); #1;
    MEN = 1'b0;
    repeat (84) @(posedge CLK);
    #3;
    check("abort in_transfer csn", 32'(spi_csn), 32'd0);
    RESET = 1'b1;
    #1;
    check("abort csn", 32'(spi_csn), 32'd1);
    check("abort sclk_mosi", {30'b0, spi_sclk, spi_mosi}, 32'd0);
    check("abort mdone", {31'b0, MDONE}, 32'd0);
    check("abort mdout", MDOUT, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    @(posedge CLK); #1;

    // Back-to-back reads with MEN held high
    model_access(32'h10, 4'h0, elat, eerr, ed, eedges);
    MADDR = 32'h10; MWE = 4'h0; MEN = 1'b1;
    @(posedge CLK); #1;
    wait_done(lat);
    check("b2b1 latency", lat, FULL_LAT);
    check("b2b1 mdout", MDOUT, 32'hDEAD_BEEF);
    check("b2b1 model", MDOUT, ed);
    check("b2b1 header", last_hdr, 32'h0300_0010);
    MADDR = 32'h14;
    @(posedge CLK); #1;
    check("b2b gap mdone", {31'b0, MDONE}, 32'd0);
    @(posedge CLK); #1;
    MEN = 1'b0;
    model_access(32'h14, 4'h0, elat, eerr, ed, eedges);
    wait_done(lat);
    check("b2b2 latency", lat, FULL_LAT);
    check("b2b2 mdout", MDOUT, ed);
    check("b2b2 header", last_hdr, 32'h0300_0014);
    check("b2b csn_gap_ge2", 32'(last_gap >= 2), 32'd1);
    @(posedge CLK); #1;

    // Repeated read of the same word: buffered when the cache is built in
    run_access("cache_fill", 32'h10, 4'h0, lat, err);
    check("cache_fill latency", lat, FULL_LAT);
    run_access("cache_repeat", 32'h10, 4'h0, lat, err);
    check("cache_repeat latency", lat, CACHE ? 1 : FULL_LAT);
    check("cache_repeat mdout", MDOUT, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_spi_flash_reader.md
Name: mem_spi_flash_reader

Overview:
- Memory-side slave that consumes the M-port (MEN/MADDR/MDIN/MWE → MDOUT/MDONE/MERROR) produced by the AHB memory interpreter.
- Serves read-only code/data from an external SPI NOR flash using the READ (0x03) command, SPI mode 0.
- Sits between the flash-region interpreter and the board flash pins; replaces the exposed flash memory port with 4 SPI pins.

Parameters:
- MEM_BYTES, 32'h0000_8000, addressable flash window in bytes; accesses at or beyond it are errors.
- SCLK_DIV, 2, SCLK half-period in CLK cycles; legal range 1..255.
- FLASH_BASE, 24'h00_0000, byte offset added to MADDR to form the SPI address.

Ports:
- CLK  in  1  single clock for all logic.
- RESET  in  1  asynchronous, active-high reset.
- MEN  in  1  access request; sampled in IDLE.
- MADDR  in  32  byte address; word aligned, bits [1:0] ignored.
- MDIN  in  32  write data; unused, writes are rejected.
- MWE  in  4  byte write enables; any bit set marks a write.
- MDOUT  out  32  read data; valid in the MDONE cycle and held until the next MDONE.
- MDONE  out  1  one-cycle completion pulse.
- MERROR  out  1  error flag; high only together with MDONE.
- spi_csn  out  1  flash chip select, active low.
- spi_sclk  out  1  SPI clock; idles low.
- spi_mosi  out  1  command/address out.
- spi_miso  in  1  data in.

Behaviour:
- Reset values: MDOUT=0, MDONE=0, MERROR=0, spi_csn=1, spi_sclk=0, spi_mosi=0, FSM=IDLE, cache invalid. Reset takes effect asynchronously, including mid-transfer (csn deasserts immediately).
- FSM states: IDLE, REJECT, SELECT, SHIFT, DONE.
- IDLE, MEN=0: stay in IDLE.
- IDLE, MEN=1 with MWE!=0 or MADDR>=MEM_BYTES: go to REJECT. Next cycle MDONE=1, MERROR=1, MDOUT unchanged, no SPI activity. Then return to IDLE.
- IDLE, MEN=1 and legal read: latch A = FLASH_BASE + {MADDR[23:2],2'b00}. Go to SELECT.
- SELECT: one cycle; spi_csn=0, spi_mosi = bit 7 of 0x03.
- SHIFT: 64 SCLK periods, each 2*SCLK_DIV CLK cycles, low half first.
  - spi_mosi changes only while sclk is low, MSB first: 8 command bits 0x03, then 24 address bits A[23:0], then 0 for the 32 data bits.
  - spi_miso is sampled on the CLK edge that raises sclk, during the last 32 periods only.
  - A bit counter (0..63) and a divider counter (0..SCLK_DIV-1) control the phase.
- Data assembly: bytes are little-endian. First received byte → MDOUT[7:0], fourth → MDOUT[31:24]; MSB-first within each byte.
- DONE: one cycle; spi_csn=1, spi_sclk=0, MDONE=1, MERROR=0, MDOUT updated. Then go to IDLE.
- Latency: MDONE is asserted 128*SCLK_DIV+2 cycles after the edge that sampled MEN in IDLE (258 cycles for SCLK_DIV=2).
- spi_csn stays high at least 2 CLK cycles between transfers (DONE + IDLE). Back-to-back requests are allowed; MEN high in IDLE starts the next access.
- Requester must hold MADDR/MWE stable until MDONE. MEN falling mid-transfer does not abort; the transfer completes and MDONE still pulses.
- MDIN is ignored in all states.

Optional Feature:
- Macro: MEM_SPI_FLASH_READER_CACHE_EN
- Defined:
  - One-entry word buffer holding tag A and data, plus a valid bit; filled at every successful DONE.
  - A legal read in IDLE whose A equals the tag while valid=1 goes to a HIT state: MDONE=1 and MDOUT=cached data on the next cycle (latency 1), with no SPI activity.
  - Valid clears on RESET only.
- Undefined: every legal read performs a full SPI transfer; no buffer or tag logic is synthesised.

Test Plan:
- Read MADDR=0x0000_0010, SCLK_DIV=2, flash model returns bytes 0xEF,0xBE,0xAD,0xDE → MOSI stream 0x03,0x00,0x00,0x10; MDONE at cycle 258; MDOUT=0xDEADBEEF; MERROR=0.
- Write MEN=1, MWE=4'hF, MADDR=0x4 → MDONE=1 and MERROR=1 the next cycle; spi_csn stays 1 throughout.
- Read MADDR=0x0000_8000 (=MEM_BYTES) → error pulse as above; MDOUT keeps its previous value 0xDEADBEEF.
- Assert RESET at bit 20 of SHIFT → spi_csn=1, sclk=0, MDONE=0 asynchronously. Next read of 0x10 completes normally with 0xDEADBEEF.
- Two back-to-back reads of 0x10 then 0x14 → spi_csn high ≥2 cycles between frames; second MOSI address 0x000014.
- With MEM_SPI_FLASH_READER_CACHE_EN: second read of 0x10 → MDONE 1 cycle after sampling, MDOUT=0xDEADBEEF, zero sclk edges. Without the macro: a full 258-cycle transfer.
